// File: rtl/logit_collector_pkg.sv
// Shared classifier constants and collector state encoding.
// No timing or flow control of its own.
package logit_collector_pkg;

   localparam int LOGIT_WIDTH = 32;
   localparam int NUM_CLASSES = 10;

   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } collector_state_t;

   localparam logic [0:0] ST_COLLECT = 1'b0;
   localparam logic [0:0] ST_HOLD    = 1'b1;

endpackage

// File: rtl/logit_collector_if.sv
// Logit stream in, completed logit vector out; valid/ready on both sides.
// Pure wiring: no latency, no storage.
interface logit_collector_if
   import logit_collector_pkg::*;
#(
   parameter int DATA_WIDTH = LOGIT_WIDTH,
   parameter int NUM_ARGS   = NUM_CLASSES
);

   logic                         in_valid;
   logic                         in_ready;
   logic signed [DATA_WIDTH-1:0] in_data;
   logic                         in_last;
   logic                         out_valid;
   logic                         out_ready;
   logic signed [DATA_WIDTH-1:0] arg_vector [NUM_ARGS];

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, arg_vector
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, arg_vector
   );

endinterface

// File: rtl/logit_collector.sv
// Gathers NUM_ARGS logits into a vector; out_valid the cycle after the last beat.
// in_ready drops while the vector is held, until out_ready acknowledges it.
module logit_collector
   import logit_collector_pkg::*;
#(
   parameter int DATA_WIDTH = LOGIT_WIDTH,
   parameter int NUM_ARGS   = NUM_CLASSES,
   parameter int IDX_WIDTH  = $clog2(NUM_ARGS),
   parameter int CNT_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   logit_collector_if.slave     bus,
   output logic                 len_err,
   output logic [CNT_WIDTH-1:0] frame_count
);

   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_ARGS - 1);

   logic [0:0]                   state_q, state_d;
   logic [IDX_WIDTH-1:0]         idx_q, idx_d;
   logic signed [DATA_WIDTH-1:0] entry_q [NUM_ARGS];
   logic signed [DATA_WIDTH-1:0] entry_d [NUM_ARGS];
   logic                         len_err_q, len_err_d;
   logic [CNT_WIDTH-1:0]         cnt_q, cnt_d;

   logic accept;
   logic last_slot;
   logic short_frame;
   logic long_frame;

   assign accept      = bus.in_valid && (state_q == ST_COLLECT);
   assign last_slot   = (idx_q == LAST_IDX);
   assign short_frame = accept && bus.in_last && !last_slot;
   assign long_frame  = accept && !bus.in_last && last_slot;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      entry_d   = entry_q;
      cnt_d     = cnt_q;
      len_err_d = short_frame || long_frame;
      case (state_q)
         ST_COLLECT: begin
            if (accept) begin
               // A truncated frame is dropped entirely so no stale class survives.
               if (short_frame) begin
                  idx_d = '0;
                  for (int i = 0; i < NUM_ARGS; i++) begin
                     entry_d[i] = '0;
                  end
               end else begin
                  for (int i = 0; i < NUM_ARGS; i++) begin
                     if (idx_q == IDX_WIDTH'(i)) begin
                        entry_d[i] = bus.in_data;
                     end
                  end
                  if (last_slot) begin
                     idx_d   = '0;
                     state_d = ST_HOLD;
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end
            end
         end
         default: begin
            if (bus.out_ready) begin
               state_d = ST_COLLECT;
               cnt_d   = cnt_q + 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_COLLECT;
         idx_q     <= '0;
         len_err_q <= 1'b0;
         cnt_q     <= '0;
         for (int i = 0; i < NUM_ARGS; i++) begin
            entry_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         len_err_q <= len_err_d;
         cnt_q     <= cnt_d;
         entry_q   <= entry_d;
      end
   end

   assign bus.in_ready   = (state_q == ST_COLLECT);
   assign bus.out_valid  = (state_q == ST_HOLD);
   assign bus.arg_vector = entry_q;
   assign len_err        = len_err_q;
   assign frame_count    = cnt_q;

   // Consumer contract: a presented vector stays up until taken.
   property p_hold_until_ack;
      @(posedge clk) disable iff (rst)
         (bus.out_valid && !bus.out_ready) |=> bus.out_valid;
   endproperty
   a_hold_until_ack: assert property (p_hold_until_ack);

   a_ready_valid_exclusive: assert property (
      @(posedge clk) disable iff (rst) !(bus.in_ready && bus.out_valid));

endmodule
